rs: RTL and testbench

- Reservation station for the out-of-order core; sits between dispatch (ID stage) and the execute stage.
- Holds one entry per functional-unit class: ALU, FP1, FP2, LD and ST.
- Captures CDB broadcasts to mark source operands ready.
- Issues at most one operand-ready instruction per cycle to execute.

---
 rtl/rs_pkg.sv | 59 +++++
 rtl/rs_entry.sv | 43 ++++
 rtl/rs.sv | 71 +++++++
 tb/tb_rs.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared system definitions for the reservation station: tag and packet layouts,
// ALU function codes, slot numbering and operand-readiness helpers.
package rs_pkg;

  localparam int unsigned TAG_W  = 6;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned NUM_RS = 5;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU
  } ALU_FUNC;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             ready;
    logic             valid;
  } TAG;

  typedef struct packed {
    logic [XLEN-1:0]  npc;
    logic [XLEN-1:0]  inst;
    logic [REG_W-1:0] dest_reg_idx;
    ALU_FUNC          alu_func;
    logic             rd_mem;
    logic             wr_mem;
    logic             illegal;
    logic             valid;
    TAG               T1;
    TAG               T2;
  } ID_EX_PACKET;

  // Slot numbering; issue priority is applied separately in the top.
  typedef enum logic [2:0] {
    SLOT_ALU = 3'd0,
    SLOT_FP1 = 3'd1,
    SLOT_FP2 = 3'd2,
    SLOT_LD  = 3'd3,
    SLOT_ST  = 3'd4
  } rs_slot_e;

  function automatic logic is_mul(input ALU_FUNC f);
    return (f == ALU_MUL) || (f == ALU_MULH) || (f == ALU_MULHSU) || (f == ALU_MULHU);
  endfunction

  // An unused operand (valid = 0) never blocks issue.
  function automatic logic op_ready(input TAG t);
    return t.ready || !t.valid;
  endfunction

  function automatic TAG wake(input TAG t, input TAG cdb);
    TAG r;
    r = t;
    if (cdb.valid && cdb.ready && t.valid && (t.tag == cdb.tag)) r.ready = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rs_entry.sv
// Single reservation-station slot: load with CDB bypass, CDB wakeup while
// waiting, clear on issue, and a combinational issuable flag.
module rs_entry
  import rs_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  ID_EX_PACKET load_pkt,
  input  TAG          cdb,
  output logic        busy,
  output ID_EX_PACKET pkt,
  output logic        ready_c
);

  ID_EX_PACKET load_woken;

  // A broadcast in the dispatch cycle is folded into the stored operands.
  always_comb begin
    load_woken    = load_pkt;
    load_woken.T1 = wake(load_pkt.T1, cdb);
    load_woken.T2 = wake(load_pkt.T2, cdb);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      pkt  <= '0;
    end else if (clear) begin
      busy <= 1'b0;
    end else if (load) begin
      busy <= 1'b1;
      pkt  <= load_woken;
    end else if (busy) begin
      pkt.T1 <= wake(pkt.T1, cdb);
      pkt.T2 <= wake(pkt.T2, cdb);
    end
  end

  assign ready_c = busy && op_ready(pkt.T1) && op_ready(pkt.T2);

endmodule

// File: rtl/rs.sv
// Reservation station: five per-class slots, dispatch routing by instruction
// class and fixed-priority single issue (ALU > LD > ST > FP1 > FP2).
module rs
  import rs_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  ID_EX_PACKET input_pkt,
  input  TAG          cdb,
  output logic        rs_busy_alu,
  output logic        rs_busy_fp1,
  output logic        rs_busy_fp2,
  output logic        rs_busy_ld,
  output logic        rs_busy_st,
  output logic        issue,
  output ID_EX_PACKET issue_pkt
);

  logic [NUM_RS-1:0] busy;
  logic [NUM_RS-1:0] ready;
  logic [NUM_RS-1:0] load;
  logic [NUM_RS-1:0] clear;
  ID_EX_PACKET       pkts [NUM_RS];
  rs_slot_e          target;

  for (genvar i = 0; i < NUM_RS; i++) begin : g_entry
    rs_entry u_entry (
      .clock    (clock),
      .reset    (reset),
      .load     (load[i]),
      .clear    (clear[i]),
      .load_pkt (input_pkt),
      .cdb      (cdb),
      .busy     (busy[i]),
      .pkt      (pkts[i]),
      .ready_c  (ready[i])
    );
  end

  // Route by class; a busy target (including one issuing now) drops the packet.
  always_comb begin
    target = SLOT_ALU;
    load   = '0;
    if (input_pkt.rd_mem)            target = SLOT_LD;
    else if (input_pkt.wr_mem)       target = SLOT_ST;
    else if (is_mul(input_pkt.alu_func))
      target = busy[SLOT_FP1] ? SLOT_FP2 : SLOT_FP1;
    if (input_pkt.valid && !input_pkt.illegal && !busy[target]) load[target] = 1'b1;
  end

  always_comb begin
    clear     = '0;
    issue_pkt = '0;
    if (ready[SLOT_ALU])      clear[SLOT_ALU] = 1'b1;
    else if (ready[SLOT_LD])  clear[SLOT_LD]  = 1'b1;
    else if (ready[SLOT_ST])  clear[SLOT_ST]  = 1'b1;
    else if (ready[SLOT_FP1]) clear[SLOT_FP1] = 1'b1;
    else if (ready[SLOT_FP2]) clear[SLOT_FP2] = 1'b1;
    for (int i = 0; i < NUM_RS; i++) begin
      if (clear[i]) issue_pkt = pkts[i];
    end
  end

  assign issue       = |clear;
  assign rs_busy_alu = busy[SLOT_ALU];
  assign rs_busy_fp1 = busy[SLOT_FP1];
  assign rs_busy_fp2 = busy[SLOT_FP2];
  assign rs_busy_ld  = busy[SLOT_LD];
  assign rs_busy_st  = busy[SLOT_ST];

endmodule

// File: tb/tb_rs.sv
// Bench for rs: directed plan plus randomized traffic, checked every cycle
// against a slot-list model of the reservation station.
module tb_rs;
  import rs_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  ID_EX_PACKET input_pkt;
  TAG          cdb;
  logic        rs_busy_alu, rs_busy_fp1, rs_busy_fp2, rs_busy_ld, rs_busy_st;
  logic        issue;
  ID_EX_PACKET issue_pkt;

  rs dut (
    .clock       (clock),
    .reset       (reset),
    .input_pkt   (input_pkt),
    .cdb         (cdb),
    .rs_busy_alu (rs_busy_alu),
    .rs_busy_fp1 (rs_busy_fp1),
    .rs_busy_fp2 (rs_busy_fp2),
    .rs_busy_ld  (rs_busy_ld),
    .rs_busy_st  (rs_busy_st),
    .issue       (issue),
    .issue_pkt   (issue_pkt)
  );

  always #5 clock = ~clock;

  // Model slots: 0 ALU, 1 FP1, 2 FP2, 3 LD, 4 ST.
  localparam int M_ALU = 0, M_FP1 = 1, M_FP2 = 2, M_LD = 3, M_ST = 4;
  logic        m_busy [5];
  ID_EX_PACKET m_pkt  [5];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic TAG tb_wake(input TAG t, input TAG c);
    TAG r = t;
    if (c.valid && c.ready && t.valid && t.tag == c.tag) r.ready = 1'b1;
    return r;
  endfunction

  function automatic int model_sel();
    int order [5] = '{M_ALU, M_LD, M_ST, M_FP1, M_FP2};
    for (int i = 0; i < 5; i++) begin
      int s = order[i];
      if (m_busy[s] && (m_pkt[s].T1.ready || !m_pkt[s].T1.valid)
                    && (m_pkt[s].T2.ready || !m_pkt[s].T2.valid)) return s;
    end
    return -1;
  endfunction

  function automatic logic [4:0] dut_busy();
    return {rs_busy_alu, rs_busy_fp1, rs_busy_fp2, rs_busy_ld, rs_busy_st};
  endfunction

  function automatic logic [4:0] model_busy();
    return {m_busy[M_ALU], m_busy[M_FP1], m_busy[M_FP2], m_busy[M_LD], m_busy[M_ST]};
  endfunction

  function automatic TAG mk_tag(input int t, input bit v, input bit r);
    TAG x;
    x.tag = TAG_W'(t);
    x.valid = v;
    x.ready = r;
    return x;
  endfunction

  function automatic ID_EX_PACKET mk_pkt(input ALU_FUNC f, input bit rd, input bit wr,
                                         input TAG t1, input TAG t2, input int id);
    ID_EX_PACKET p = '0;
    p.npc = 32'h1000 + 32'(id) * 4;
    p.inst = 32'hA000_0000 | 32'(id);
    p.dest_reg_idx = REG_W'(id);
    p.alu_func = f;
    p.rd_mem = rd;
    p.wr_mem = wr;
    p.valid = 1'b1;
    p.T1 = t1;
    p.T2 = t2;
    return p;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      m_busy[i] = 1'b0;
      m_pkt[i]  = '0;
    end
    #2;
    check("reset_busy", 128'(dut_busy()), 128'(5'b0));
    check("reset_issue", 128'(issue), 128'(1'b0));
    check("reset_pkt", 128'(issue_pkt), 128'(0));
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // One cycle: drive, compare at negedge, advance the model across the edge.
  task automatic step(input ID_EX_PACKET p, input TAG c);
    logic ob [5];
    int k, t;
    ID_EX_PACKET exp_pkt;
    input_pkt = p;
    cdb = c;
    @(negedge clock);
    k = model_sel();
    exp_pkt = (k >= 0) ? m_pkt[k] : '0;
    check("busy", 128'(dut_busy()), 128'(model_busy()));
    check("issue", 128'(issue), 128'(k >= 0));
    check("issue_pkt", 128'(issue_pkt), 128'(exp_pkt));
    ob = m_busy;
    for (int i = 0; i < 5; i++) begin
      if (ob[i]) begin
        m_pkt[i].T1 = tb_wake(m_pkt[i].T1, c);
        m_pkt[i].T2 = tb_wake(m_pkt[i].T2, c);
      end
    end
    if (k >= 0) m_busy[k] = 1'b0;
    if (p.valid && !p.illegal) begin
      if (p.rd_mem) t = M_LD;
      else if (p.wr_mem) t = M_ST;
      else if (p.alu_func inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU})
        t = ob[M_FP1] ? M_FP2 : M_FP1;
      else t = M_ALU;
      if (!ob[t]) begin
        m_busy[t] = 1'b1;
        m_pkt[t] = p;
        m_pkt[t].T1 = tb_wake(p.T1, c);
        m_pkt[t].T2 = tb_wake(p.T2, c);
      end
    end
    @(posedge clock);
    #1;
  endtask

  function automatic ID_EX_PACKET rand_pkt(input int id);
    ID_EX_PACKET p;
    p = mk_pkt(ALU_FUNC'($urandom_range(0, 13)), $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0,
               mk_tag($urandom_range(1, 6), $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0),
               mk_tag($urandom_range(1, 6), $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0),
               id);
    p.npc = $urandom;
    p.valid = $urandom_range(0, 3) != 0;
    p.illegal = $urandom_range(0, 7) == 0;
    return p;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    ID_EX_PACKET idle, p;
    TAG no_cdb;
    idle = '0;
    no_cdb = '0;
    input_pkt = '0;
    cdb = '0;
    reset = 1'b0;
    #1;
    do_reset();

    // Four dispatches, nothing ready; CDB valid without ready must not wake.
    step(mk_pkt(ALU_ADD, 0, 0, mk_tag(1, 1, 0), mk_tag(2, 1, 0), 1), no_cdb);
    check("plan_alu_rise", 128'(dut_busy()), 128'(5'b10000));
    step(mk_pkt(ALU_ADD, 1, 0, mk_tag(3, 1, 0), mk_tag(4, 1, 0), 2), mk_tag(1, 1, 0));
    check("plan_ld_rise", 128'(dut_busy()), 128'(5'b10010));
    step(mk_pkt(ALU_ADD, 0, 1, mk_tag(5, 1, 0), mk_tag(6, 1, 0), 3), mk_tag(2, 1, 0));
    check("plan_st_rise", 128'(dut_busy()), 128'(5'b10011));
    step(mk_pkt(ALU_MUL, 0, 0, mk_tag(5, 1, 0), mk_tag(6, 1, 0), 4), mk_tag(1, 1, 0));
    check("plan_fp1_rise", 128'(dut_busy()), 128'(5'b11011));
    check("plan_no_issue", 128'(issue), 128'(1'b0));
    step(mk_pkt(ALU_MUL, 0, 0, mk_tag(7, 1, 0), mk_tag(8, 1, 0), 5), mk_tag(1, 1, 1));
    check("plan_fp2_rise", 128'(dut_busy()), 128'(5'b11111));
    check("plan_half_ready", 128'(issue), 128'(1'b0));
    step(mk_pkt(ALU_MUL, 0, 0, mk_tag(7, 1, 0), mk_tag(8, 1, 0), 6), mk_tag(2, 1, 1));
    check("plan_add_issue", 128'(issue), 128'(1'b1));
    check("plan_add_inst", 128'(issue_pkt.inst), 128'(32'hA000_0001));
    check("plan_add_rdy", 128'({issue_pkt.T1.ready, issue_pkt.T2.ready}), 128'(2'b11));
    step(idle, no_cdb);
    check("plan_alu_clear", 128'(rs_busy_alu), 128'(1'b0));
    check("plan_mul3_dropped", 128'(issue), 128'(1'b0));
    step(idle, no_cdb);

    // ALU and FP1 woken together: ALU first, FP1 the following cycle.
    do_reset();
    step(mk_pkt(ALU_ADD, 0, 0, mk_tag(9, 1, 0), mk_tag(0, 0, 0), 10), no_cdb);
    step(mk_pkt(ALU_MULH, 0, 0, mk_tag(9, 1, 0), mk_tag(0, 0, 0), 11), no_cdb);
    step(idle, mk_tag(9, 1, 1));
    check("prio_alu_first", 128'(issue_pkt.inst), 128'(32'hA000_000A));
    step(idle, no_cdb);
    check("prio_fp1_next", 128'(issue_pkt.inst), 128'(32'hA000_000B));
    check("prio_busy", 128'(dut_busy()), 128'(5'b01000));
    step(idle, no_cdb);

    // Unused T1 and ready T2 issue one cycle after dispatch.
    step(mk_pkt(ALU_SUB, 0, 0, mk_tag(3, 0, 0), mk_tag(4, 1, 1), 12), no_cdb);
    check("ready_on_dispatch", 128'(issue), 128'(1'b1));
    p = mk_pkt(ALU_ADD, 0, 0, mk_tag(1, 1, 0), mk_tag(2, 1, 0), 13);
    p.illegal = 1'b1;
    step(p, no_cdb);
    check("illegal_drop", 128'(dut_busy()), 128'(5'b0));
    p.illegal = 1'b0;
    p.valid = 1'b0;
    step(p, no_cdb);
    check("invalid_drop", 128'(dut_busy()), 128'(5'b0));

    // Dispatch-cycle bypass of a matching broadcast.
    step(mk_pkt(ALU_ADD, 1, 0, mk_tag(5, 1, 0), mk_tag(5, 1, 0), 14), mk_tag(5, 1, 1));
    check("bypass_issue", 128'(issue), 128'(1'b1));
    step(idle, no_cdb);

    // Randomized traffic with occasional asynchronous flushes.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      step(rand_pkt(100 + n),
           mk_tag($urandom_range(1, 6), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
